sha256_msg_padder: RTL

// - Host-side feeder for sha256_core: accepts a message as a byte stream, applies FIPS 180-4 padding
//   (0x80, zeros, 64-bit big-endian bit length), packs 512-bit blocks and drives core init/next.
// - Sits between the coprocessor bus/DMA byte source and sha256_core; digest is read directly from the core.

---
 rtl/sha256_msg_padder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_padder.sv
// Byte-stream front end for sha256_core: applies SHA-256 padding, packs 512-bit blocks and drives init/next.
// Optional zero-length message support via `define SHA256_PADDER_ZEROLEN_EN (adds in_empty).
module sha256_msg_padder #(
  parameter int   LEN_W = 64,
  parameter logic MODE  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
`ifdef SHA256_PADDER_ZEROLEN_EN
  input  logic         in_empty,
`endif
  output logic         in_ready,
  output logic         core_init,
  output logic         core_next,
  output logic         core_mode,
  output logic [511:0] core_block,
  input  logic         core_ready,
  output logic         busy,
  output logic         msg_done
);
  localparam int CNT_W = LEN_W - 3;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PAD, S_PADLEN, S_ISSUE, S_HOLD, S_WAIT
  } state_t;

  state_t             state_q, state_d;
  state_t             after_q, after_d;
  logic [511:0]       block_q, block_d;
  logic [5:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic               done_q, done_d;
  logic               xfer;
  logic               len_fits;
  logic [63:0]        len_bits;
  logic [511:0]       fill_blk, pad_blk, len_blk;

  assign len_bits   = 64'({cnt_q, 3'b000});
  assign len_fits   = (idx_q <= 6'd55);
  assign in_ready   = !reset && (state_q == S_IDLE || state_q == S_FILL);
  assign xfer       = in_valid && in_ready;
  assign core_mode  = MODE;
  assign core_block = block_q;
  assign busy       = (state_q != S_IDLE);
  assign msg_done   = done_q;

  // Per-byte candidates: incoming byte write, padding mask, and length-only block.
  for (genvar gi = 0; gi < 64; gi++) begin : g_byte
    localparam logic [5:0] BI = 6'(gi);
    logic [7:0] cur;
    logic [7:0] len_byte;
    assign cur = block_q[511-8*gi -: 8];
    if (gi >= 56) begin : g_len
      assign len_byte = len_bits[8*(63-gi) +: 8];
    end else begin : g_nolen
      assign len_byte = 8'h00;
    end
    assign fill_blk[511-8*gi -: 8] = (idx_q == BI) ? in_data : cur;
    assign pad_blk[511-8*gi -: 8]  = (BI < idx_q)  ? cur :
                                     (BI == idx_q) ? 8'h80 :
                                     (len_fits ? len_byte : 8'h00);
    assign len_blk[511-8*gi -: 8]  = len_byte;
  end

  always_comb begin
    state_d   = state_q;
    after_d   = after_q;
    block_d   = block_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    done_d    = 1'b0;
    core_init = 1'b0;
    core_next = 1'b0;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (xfer) begin
          block_d = fill_blk;
          idx_d   = idx_q + 6'd1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (state_q == S_IDLE) first_d = 1'b1;
          if (in_last) begin
            // A last byte that fills the block still needs a separate padding block.
            if (idx_q == 6'd63) begin
              state_d = S_ISSUE;
              after_d = S_PAD;
            end else begin
              state_d = S_PAD;
            end
          end else if (idx_q == 6'd63) begin
            state_d = S_ISSUE;
            after_d = S_FILL;
          end else begin
            state_d = S_FILL;
          end
        end
`ifdef SHA256_PADDER_ZEROLEN_EN
        else if (state_q == S_IDLE && in_empty) begin
          first_d = 1'b1;
          state_d = S_PAD;
        end
`endif
      end
      S_PAD: begin
        block_d = pad_blk;
        idx_d   = 6'd0;
        after_d = len_fits ? S_IDLE : S_PADLEN;
        state_d = S_ISSUE;
      end
      S_PADLEN: begin
        block_d = len_blk;
        after_d = S_IDLE;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (core_ready) begin
          core_init = first_q;
          core_next = !first_q;
          first_d   = 1'b0;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: state_d = S_WAIT;
      S_WAIT: begin
        if (core_ready) begin
          if (after_q == S_IDLE) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            idx_d   = 6'd0;
            state_d = S_IDLE;
          end else begin
            state_d = after_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      after_q <= S_IDLE;
      block_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      after_q <= after_d;
      block_q <= block_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end
endmodule
